// File: rtl/digiota_stim_meter.sv
// digiota_stim_meter
//   Stimulus and measurement stage around the analog OTA macro.
//   - A first-order sigma-delta modulator turns i_code into a bitstream on o_sd_out.
//     The bitstream is RC-filtered off-chip into the OTA input.
//   - A 2-flop synchronizer brings the comparator output i_cmp_in into the clock domain.
//   - On i_start the block settles for SETTLE_CYC cycles, then counts comparator-high
//     cycles over a window of i_win_len+1 cycles. The count is reported on o_result
//     together with a one-cycle o_done pulse.
//
// Build option: define DIGIOTA_STIM_DITHER_EN to add a 16-bit LFSR dither bit to the
//   modulator sum. This breaks idle tones and adds a mean +0.5 LSB bias.
//
// Ports
//   i_clk      single clock
//   i_rst      synchronous active-high reset
//   i_ena      global enable; low freezes every register
//   i_code     modulator input; duty = code / 2^ACC_W
//   o_sd_out   registered bitstream
//   i_cmp_in   asynchronous comparator output
//   i_start    measurement request, level-sampled in idle
//   i_win_len  window length minus one, captured at start
//   o_busy     high while settling or measuring
//   o_done     one-cycle pulse when o_result is updated
//   o_result   comparator-high count, held until the next done
module digiota_stim_meter #(
  parameter int unsigned ACC_W      = 8,
  parameter int unsigned WIN_W      = 12,
  parameter int unsigned SETTLE_CYC = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_ena,
  input  logic [ACC_W-1:0] i_code,
  output logic             o_sd_out,
  input  logic             i_cmp_in,
  input  logic             i_start,
  input  logic [WIN_W-1:0] i_win_len,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIN_W:0]   o_result
);

  localparam int unsigned SUM_W = ACC_W + 1;
  localparam int unsigned CNT_W = WIN_W + 1;
  localparam int unsigned SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [SET_W-1:0] SetLast = SET_W'(SETTLE_CYC - 1);

  typedef enum logic [1:0] {StIdle, StSettle, StMeasure, StDone} state_e;

  state_e             r_state;
  logic [ACC_W-1:0]   r_acc;
  logic               r_sd;
  logic               r_cmp_meta;
  logic               r_cmp_s;
  logic [WIN_W-1:0]   r_win;
  logic [WIN_W-1:0]   r_win_cnt;
  logic [SET_W-1:0]   r_set_cnt;
  logic [CNT_W-1:0]   r_hits;
  logic [CNT_W-1:0]   r_result;
  logic               r_busy;
  logic               r_done;
  logic [SUM_W-1:0]   w_sum;

`ifdef DIGIOTA_STIM_DITHER_EN
  logic [15:0] r_lfsr;
  logic        w_lfsr_fb;

  // Fibonacci taps for x^16 + x^14 + x^13 + x^11 + 1
  assign w_lfsr_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
  assign w_sum = {1'b0, r_acc} + {1'b0, i_code} + SUM_W'(r_lfsr[0]);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_lfsr <= 16'hACE1;
    end else if (i_ena) begin
      r_lfsr <= {r_lfsr[14:0], w_lfsr_fb};
    end
  end
`else
  assign w_sum = {1'b0, r_acc} + {1'b0, i_code};
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= StIdle;
      r_acc      <= '0;
      r_sd       <= 1'b0;
      r_cmp_meta <= 1'b0;
      r_cmp_s    <= 1'b0;
      r_win      <= '0;
      r_win_cnt  <= '0;
      r_set_cnt  <= '0;
      r_hits     <= '0;
      r_result   <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else if (i_ena) begin
      // Modulator runs continuously; the carry out is the bitstream.
      r_acc      <= w_sum[ACC_W-1:0];
      r_sd       <= w_sum[ACC_W];
      r_cmp_meta <= i_cmp_in;
      r_cmp_s    <= r_cmp_meta;
      r_done     <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (i_start) begin
            r_win     <= i_win_len;
            r_win_cnt <= '0;
            r_set_cnt <= '0;
            r_hits    <= '0;
            r_busy    <= 1'b1;
            r_state   <= StSettle;
          end
        end
        StSettle: begin
          if (r_set_cnt == SetLast) begin
            r_set_cnt <= '0;
            r_state   <= StMeasure;
          end else begin
            r_set_cnt <= r_set_cnt + SET_W'(1);
          end
        end
        StMeasure: begin
          // Window of r_win+1 cycles; the hit counter is one bit wider so it cannot wrap.
          if (r_cmp_s) begin
            r_hits <= r_hits + CNT_W'(1);
          end
          if (r_win_cnt == r_win) begin
            r_busy  <= 1'b0;
            r_state <= StDone;
          end else begin
            r_win_cnt <= r_win_cnt + WIN_W'(1);
          end
        end
        StDone: begin
          r_result <= r_hits;
          r_done   <= 1'b1;
          r_state  <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_sd_out = r_sd;
  assign o_busy   = r_busy;
  assign o_done   = r_done;
  assign o_result = r_result;

endmodule

// File: tb/tb_digiota_stim_meter.sv
// Directed bench for digiota_stim_meter at default parameters (SETTLE_CYC=16).
module tb_digiota_stim_meter;

  localparam int S = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        ena;
  logic [7:0]  code;
  logic        sd_out;
  logic        cmp_in;
  logic        cmp_drv;
  logic        loop_en;
  logic        start;
  logic [11:0] win_len;
  logic        busy;
  logic        done;
  logic [12:0] result;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  assign cmp_in = loop_en ? sd_out : cmp_drv;

  always #5 clk = ~clk;

  digiota_stim_meter dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_ena     (ena),
    .i_code    (code),
    .o_sd_out  (sd_out),
    .i_cmp_in  (cmp_in),
    .i_start   (start),
    .i_win_len (win_len),
    .o_busy    (busy),
    .o_done    (done),
    .o_result  (result)
  );

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Steps until done is seen or the limit expires; n = edges stepped.
  task automatic wait_done(input int limit, output int n);
    n = 0;
    while (done !== 1'b1 && n < limit) begin
      step();
      n++;
    end
  endtask

  // Pulses start for one edge (edge k), then returns the edge count from k to done.
  task automatic run_meas(input logic [11:0] win, output int lat);
    int n;
    win_len = win;
    start   = 1'b1;
    step();
    start = 1'b0;
    wait_done(5000, n);
    lat = n;
  endtask

  initial begin
    int lat;
    int n;
    int t1;
    int t2;
    int seen;

    rst = 1'b1; ena = 1'b1; code = 8'd0; cmp_drv = 1'b0; loop_en = 1'b0;
    start = 1'b0; win_len = 12'd0;
    step();
    chk("rst_sd_out", 32'(sd_out), 0);
    chk("rst_busy",   32'(busy),   0);
    chk("rst_done",   32'(done),   0);
    chk("rst_result", 32'(result), 0);

    // code=64: carry on every 4th enabled edge.
    rst  = 1'b0;
    code = 8'd64;
    seen = 0;
    for (int i = 1; i <= 16; i++) begin
      step();
      if (sd_out !== ((i % 4) == 0)) seen++;
      if (busy !== 1'b0 || done !== 1'b0 || result !== 13'd0) seen++;
    end
    chk("sd_pattern_64_errors", seen, 0);

    // Comparator tied high, 100-cycle window.
    cmp_drv = 1'b1;
    repeat (3) step();
    win_len = 12'd99;
    start   = 1'b1;
    step();
    start = 1'b0;
    chk("busy_after_start", 32'(busy), 1);
    seen = 0;
    for (int i = 1; i < S + 101; i++) begin
      step();
      if (done !== 1'b0) seen++;
    end
    chk("no_early_done", seen, 0);
    step();
    chk("done_at_117",     32'(done),   1);
    chk("result_all_ones", 32'(result), 100);
    chk("busy_low_in_done", 32'(busy),  0);
    step();
    chk("done_one_cycle", 32'(done),   0);
    chk("result_held",    32'(result), 100);

    cmp_drv = 1'b0;
    repeat (3) step();
    run_meas(12'd99, lat);
    chk("lat_zeros",       lat,         S + 99 + 2);
    chk("result_all_zero", 32'(result), 0);

    // Loopback of the bitstream into the comparator input.
    rst = 1'b1;
    step();
    rst     = 1'b0;
    code    = 8'd64;
    loop_en = 1'b1;
    repeat (10) step();
    run_meas(12'd255, lat);
    chk("lat_loop64",    lat,         S + 255 + 2);
    chk("result_loop64", 32'(result), 64);
    code = 8'd255;
    repeat (10) step();
    run_meas(12'd255, lat);
    chk("result_loop255", 32'(result), 255);
    loop_en = 1'b0;

    // start held high: one idle cycle between measurements.
    cmp_drv = 1'b1;
    repeat (3) step();
    win_len = 12'd7;
    start   = 1'b1;
    wait_done(200, n);
    t1 = cyc;
    chk("held_first_done",   32'(done),   1);
    chk("held_first_result", 32'(result), 8);
    step();
    chk("held_relaunch_busy", 32'(busy), 1);
    wait_done(200, n);
    t2 = cyc;
    start = 1'b0;
    chk("held_period",        t2 - t1,     S + 7 + 3);
    chk("held_second_result", 32'(result), 8);
    step();
    chk("held_stop_busy", 32'(busy), 0);

    // start pulses during SETTLE and MEASURE are ignored.
    win_len = 12'd7;
    start   = 1'b1;
    step();
    start = 1'b0;
    repeat (5) step();
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (13) step();
    start = 1'b1;
    step();
    start = 1'b0;
    wait_done(200, n);
    chk("ignored_start_lat", 20 + n, S + 7 + 2);
    step();
    chk("ignored_no_relaunch", 32'(busy), 0);
    chk("ignored_done_low",    32'(done), 0);

    // Reset mid-MEASURE.
    win_len = 12'd99;
    start   = 1'b1;
    step();
    start = 1'b0;
    repeat (40) step();
    rst = 1'b1;
    step();
    chk("midrst_busy",   32'(busy),   0);
    chk("midrst_done",   32'(done),   0);
    chk("midrst_result", 32'(result), 0);
    chk("midrst_sd_out", 32'(sd_out), 0);
    rst  = 1'b0;
    code = 8'd0;
    wait_done(200, n);
    chk("midrst_no_done", n, 200);
    repeat (2) step();
    run_meas(12'd9, lat);
    chk("post_rst_lat",    lat,         S + 9 + 2);
    chk("post_rst_result", 32'(result), 10);

    // ena low for 10 cycles mid-MEASURE.
    win_len = 12'd49;
    start   = 1'b1;
    step();
    start = 1'b0;
    repeat (29) step();
    ena = 1'b0;
    repeat (10) step();
    chk("ena_freeze_busy", 32'(busy), 1);
    chk("ena_freeze_done", 32'(done), 0);
    ena = 1'b1;
    wait_done(300, n);
    chk("ena_lat",    29 + 10 + n, S + 49 + 2 + 10);
    chk("ena_result", 32'(result), 50);
    ena = 1'b0;
    repeat (3) step();
    chk("done_stretched", 32'(done), 1);
    ena = 1'b1;
    step();
    chk("done_released", 32'(done), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
